// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Registers the MEM-stage instruction for one cycle, pairs it with the data SRAM read word
// (which arrives one cycle after the address), performs byte/half/word load extraction with
// sign/zero extension, and selects the register-file write-back value.
//
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   stall, flush          - hold contents / insert bubble (flush wins)
//   in_valid, MemtoReg,   - MEM-stage control
//   RegWrite, MemRead,
//   mem_unsigned
//   Aluout, rd            - ALU result / load address and destination register
//   data_sram_rdata       - SRAM read word, valid the cycle after the address
//   valid_out             - WB holds a real instruction
//   RegWrite_out, rd_out  - register-file write enable and address
//   wb_data               - write-back data (0 for a bubble)
//   load_data             - extracted load value
module mem_wb_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               MemtoReg,
  input  logic               RegWrite,
  input  logic [1:0]         MemRead,
  input  logic               mem_unsigned,
  input  logic [DATA_W-1:0]  Aluout,
  input  logic [RADDR_W-1:0] rd,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  output logic               valid_out,
  output logic               RegWrite_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  load_data
);

  localparam logic [1:0] MemNone = 2'b00;
  localparam logic [1:0] MemByte = 2'b01;
  localparam logic [1:0] MemHalf = 2'b10;
  localparam logic [1:0] MemWord = 2'b11;

  logic               valid_q;
  logic               RegWrite_q;
  logic               MemtoReg_q;
  logic [1:0]         MemRead_q;
  logic               unsigned_q;
  logic [RADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]  alu_q;
  logic               held_q;
  logic [DATA_W-1:0]  rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      RegWrite_q <= 1'b0;
      MemtoReg_q <= 1'b0;
      MemRead_q  <= MemNone;
      unsigned_q <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      held_q     <= 1'b0;
      rdata_q    <= '0;
    end else if (flush) begin
      // Only the fields that make the slot architecturally visible are cleared.
      valid_q    <= 1'b0;
      RegWrite_q <= 1'b0;
      MemRead_q  <= MemNone;
      held_q     <= 1'b0;
    end else if (stall) begin
      // The SRAM word is only live during the first WB cycle; latch it before the
      // address moves on so a stalled load keeps its data.
      if (!held_q && (MemRead_q != MemNone)) begin
        rdata_q <= data_sram_rdata;
        held_q  <= 1'b1;
      end
    end else begin
      valid_q    <= in_valid;
      RegWrite_q <= RegWrite;
      MemtoReg_q <= MemtoReg;
      MemRead_q  <= MemRead;
      unsigned_q <= mem_unsigned;
      rd_q       <= rd;
      alu_q      <= Aluout;
      held_q     <= 1'b0;
    end
  end

  logic [DATA_W-1:0] word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    word = held_q ? rdata_q : data_sram_rdata;

    byte_sel = 8'h00;
    case (alu_q[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    // Address bit 0 is ignored for halves; misalignment is not trapped.
    half_sel = alu_q[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (MemRead_q)
      MemByte: load_data = {{(DATA_W-8){byte_sel[7] & ~unsigned_q}}, byte_sel};
      MemHalf: load_data = {{(DATA_W-16){half_sel[15] & ~unsigned_q}}, half_sel};
      MemWord: load_data = word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    valid_out    = valid_q;
    rd_out       = rd_q;
    RegWrite_out = valid_q & RegWrite_q & (rd_q != '0);
    wb_data      = '0;
    if (valid_q) begin
      wb_data = MemtoReg_q ? load_data : alu_q;
    end
  end

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        MemtoReg;
  logic        RegWrite;
  logic [1:0]  MemRead;
  logic        mem_unsigned;
  logic [31:0] Aluout;
  logic [4:0]  rd;
  logic [31:0] data_sram_rdata;
  logic        valid_out;
  logic        RegWrite_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  mem_wb_reg #(
    .DATA_W (32),
    .RADDR_W(5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .in_valid       (in_valid),
    .MemtoReg       (MemtoReg),
    .RegWrite       (RegWrite),
    .MemRead        (MemRead),
    .mem_unsigned   (mem_unsigned),
    .Aluout         (Aluout),
    .rd             (rd),
    .data_sram_rdata(data_sram_rdata),
    .valid_out      (valid_out),
    .RegWrite_out   (RegWrite_out),
    .rd_out         (rd_out),
    .wb_data        (wb_data),
    .load_data      (load_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic m2r, input logic rw, input logic [1:0] mr,
                           input logic uns, input logic [31:0] alu, input logic [4:0] dst);
    in_valid     = v;
    MemtoReg     = m2r;
    RegWrite     = rw;
    MemRead      = mr;
    mem_unsigned = uns;
    Aluout       = alu;
    rd           = dst;
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    flush           = 1'b0;
    data_sram_rdata = 32'h0;
    set_instr(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 5'd0);
    #12;
    chk("reset valid_out", {31'b0, valid_out}, 32'h0);
    chk("reset RegWrite_out", {31'b0, RegWrite_out}, 32'h0);
    chk("reset rd_out", {27'b0, rd_out}, 32'h0);
    chk("reset wb_data", wb_data, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    reset = 1'b0;

    // lw 0x100 -> rd 5
    set_instr(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 5'd5);
    step();
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("lw valid_out", {31'b0, valid_out}, 32'h1);
    chk("lw RegWrite_out", {31'b0, RegWrite_out}, 32'h1);
    chk("lw rd_out", {27'b0, rd_out}, 32'h5);
    chk("lw wb_data", wb_data, 32'hDEADBEEF);

    // Byte/half extraction against word 0x80112233
    set_instr(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h103, 5'd3);
    step();
    data_sram_rdata = 32'h80112233;
    #1;
    chk("lb 0x103", wb_data, 32'hFFFFFF80);
    chk("lb load_data", load_data, 32'hFFFFFF80);
    set_instr(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h103, 5'd3);
    step();
    chk("lbu 0x103", wb_data, 32'h00000080);
    set_instr(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h101, 5'd3);
    step();
    chk("lb 0x101", wb_data, 32'h00000022);
    set_instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 5'd4);
    step();
    chk("lh 0x102", wb_data, 32'hFFFF8011);
    set_instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h101, 5'd4);
    step();
    chk("lhu 0x101", wb_data, 32'h00002233);

    // lw held across a 3-cycle stall while the SRAM word changes
    set_instr(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h200, 5'd6);
    step();
    data_sram_rdata = 32'h11111111;
    #1;
    chk("stall first", wb_data, 32'h11111111);
    stall = 1'b1;
    set_instr(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h55, 5'd7);
    step();
    data_sram_rdata = 32'h22222222;
    #1;
    chk("stall 1 wb_data", wb_data, 32'h11111111);
    chk("stall 1 rd_out", {27'b0, rd_out}, 32'h6);
    step();
    data_sram_rdata = 32'h33333333;
    #1;
    chk("stall 2 wb_data", wb_data, 32'h11111111);
    step();
    chk("stall 3 wb_data", wb_data, 32'h11111111);
    stall = 1'b0;
    step();
    chk("post-stall wb_data", wb_data, 32'h00000055);
    chk("post-stall rd_out", {27'b0, rd_out}, 32'h7);
    chk("post-stall load_data", load_data, 32'h0);

    // ALU write-back to x0 is suppressed
    set_instr(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h2A, 5'd0);
    step();
    chk("add x0 RegWrite_out", {31'b0, RegWrite_out}, 32'h0);
    chk("add x0 wb_data", wb_data, 32'h0000002A);
    set_instr(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h2A, 5'd7);
    step();
    chk("add x7 RegWrite_out", {31'b0, RegWrite_out}, 32'h1);

    // Flush beats stall on a held lw
    set_instr(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h300, 5'd8);
    step();
    data_sram_rdata = 32'hA5A5A5A5;
    #1;
    chk("pre-flush valid_out", {31'b0, valid_out}, 32'h1);
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    chk("flush valid_out", {31'b0, valid_out}, 32'h0);
    chk("flush RegWrite_out", {31'b0, RegWrite_out}, 32'h0);
    chk("flush wb_data", wb_data, 32'h0);

    // Async reset in the middle of a stalled load
    set_instr(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h400, 5'd9);
    step();
    data_sram_rdata = 32'h12345678;
    stall = 1'b1;
    step();
    data_sram_rdata = 32'h0BADF00D;
    #1;
    chk("held before reset", wb_data, 32'h12345678);
    reset = 1'b1;
    #1;
    chk("async reset valid_out", {31'b0, valid_out}, 32'h0);
    chk("async reset wb_data", wb_data, 32'h0);
    chk("async reset rd_out", {27'b0, rd_out}, 32'h0);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    set_instr(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h104, 5'd10);
    step();
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    chk("after reset valid_out", {31'b0, valid_out}, 32'h1);
    chk("after reset rd_out", {27'b0, rd_out}, 32'd10);
    chk("after reset wb_data", wb_data, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- MEM/WB pipeline register of the 5-stage CPU. Sits directly downstream of the MEM stage and consumes its control, ALU result and destination-register outputs.
- Pairs the registered instruction with the data SRAM read word, which returns one cycle after the MEM-stage address.
- Performs load byte/half/word extraction with sign/zero extension and selects the register-file write-back data.
- Supports pipeline stall (hold) and flush (bubble).

Parameters:
DATA_W, 32, datapath / SRAM word width (byte lanes = DATA_W/8; only 32 supported for extraction)
RADDR_W, 5, register-file address width

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hold register contents (WB not advancing)
flush  input  1  load a bubble instead of the incoming instruction
in_valid  input  1  MEM stage holds a real instruction
MemtoReg  input  1  write-back selects load data (1) or ALU result (0)
RegWrite  input  1  instruction writes the register file
MemRead  input  2  00 none, 01 byte, 10 half, 11 word
mem_unsigned  input  1  zero-extend byte/half loads (lbu/lhu)
Aluout  input  DATA_W  ALU result / load address from MEM stage
rd  input  RADDR_W  destination register
data_sram_rdata  input  DATA_W  data SRAM read word, valid the cycle after address
valid_out  output  1  WB holds a real instruction
RegWrite_out  output  1  register-file write enable
rd_out  output  RADDR_W  write address
wb_data  output  DATA_W  write-back data
load_data  output  DATA_W  extracted load value (debug/forwarding)

Behaviour:
- Reset (async, immediate): valid_q, RegWrite_q, MemtoReg_q, MemRead_q, unsigned_q, rd_q, alu_q, held_q, rdata_q all 0.
  - Outputs during reset: valid_out=0, RegWrite_out=0, rd_out=0, wb_data=0, load_data=0.
- Register update, priority order flush > stall > advance:
  - flush=1: valid_q←0, RegWrite_q←0, MemRead_q←00, held_q←0; other fields don't-care. Flush also wins over a simultaneous stall.
  - stall=1 (no flush): all instruction fields hold.
  - Otherwise: capture every input; valid_q←in_valid; held_q←0.
- Latency: one cycle from MEM inputs to WB outputs.
- SRAM data hold:
  - In the first cycle an instruction occupies WB (held_q=0), the word used is live data_sram_rdata.
  - If stall=1 in that cycle and MemRead_q≠00: rdata_q←data_sram_rdata, held_q←1.
  - While held_q=1 the word used is rdata_q; live rdata is ignored, since the SRAM address may have moved.
- Extraction uses word w (live or held) and a=alu_q[1:0]:
  - byte: lane a (a=0 → w[7:0] ... a=3 → w[31:24]).
  - half: a[1]=0 → w[15:0], a[1]=1 → w[31:16]; a[0] ignored, no misalignment trap.
  - word: w; a ignored.
  - Extension: sign-extend unless unsigned_q=1; zero-extend if unsigned_q=1.
  - MemRead_q=00 → load_data=0.
- wb_data = MemtoReg_q ? load_data : alu_q; forced to 0 when valid_q=0.
- RegWrite_out = valid_q & RegWrite_q & (rd_q≠0). rd_out = rd_q.
- All outputs are combinational from registered state plus data_sram_rdata; there is no input→output path other than data_sram_rdata.
- Reset mid-stall clears held_q; the held instruction is lost (a bubble).

Test Plan:
- lw, addr 0x100, rd=5, MemtoReg=1, RegWrite=1; next-cycle rdata=0xDEADBEEF → valid_out=1, RegWrite_out=1, rd_out=5, wb_data=0xDEADBEEF.
- lb at addr 0x103 with rdata=0x80112233 → wb_data=0xFFFFFF80; same as lbu → 0x00000080; lh at 0x102 → 0xFFFF8011; lhu at 0x101 → 0x00002233.
- lw captured, then stall=1 for 3 cycles while rdata changes 0x11111111→0x22222222→0x33333333 → wb_data stays 0x11111111 throughout; after stall drops, next instruction advances.
- add result 0x0000002A, rd=0, RegWrite=1 → RegWrite_out=0, wb_data=0x2A; repeat with rd=7 → RegWrite_out=1.
- flush=1 and stall=1 together while holding a valid lw → next cycle valid_out=0, RegWrite_out=0, wb_data=0.
- reset asserted asynchronously mid-cycle while holding a load → outputs 0 immediately; after release, the first instruction is captured normally.
